// File: rtl/pc88_ldr_pkg.sv
// pc88_ldr_pkg: shared types and constants for the loader sink.
//   ldr_state_t : handshake/flush FSM states
//   ldr_dec_t   : what to do with an incoming byte given the pending buffer
//   BE_*        : byte-enable patterns for 16-bit word writes
package pc88_ldr_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, WRITE, ACK, EOF, DONE} ldr_state_t;
  typedef enum logic [1:0] {D_STORE, D_FLUSH, D_LONE, D_MERGE} ldr_dec_t;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;
endpackage

// File: rtl/ldr_pack.sv
// ldr_pack: pending even-byte buffer plus merge/flush decision.
//   clk_i, rst_i          : clock, async active-high reset
//   adr_i, dat_i          : byte being evaluated
//   take_i                : apply the decision (load or consume the buffer)
//   clr_i                 : pending byte has been flushed to memory
//   dec_o                 : STORE / FLUSH / LONE / MERGE
//   wdata_o, be_o         : word write for LONE / MERGE
//   pend_v_o/word_o/byte_o: buffer contents
module ldr_pack
  import pc88_ldr_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [7:0]        dat_i,
  input  logic              take_i,
  input  logic              clr_i,
  output ldr_dec_t          dec_o,
  output logic [15:0]       wdata_o,
  output logic [1:0]        be_o,
  output logic              pend_v_o,
  output logic [ADDR_W-2:0] pend_word_o,
  output logic [7:0]        pend_byte_o
);
  logic              pend_v_q;
  logic [ADDR_W-2:0] pend_word_q;
  logic [7:0]        pend_byte_q;
  logic [ADDR_W-2:0] w;
  assign w = adr_i[ADDR_W-1:1];
  // The buffer only ever holds an even byte, so any even byte or an odd byte
  // of a different word forces the pending byte out first.
  always_comb begin
    dec_o   = (pend_v_q && (w != pend_word_q || !adr_i[0])) ? D_FLUSH :
              !adr_i[0] ? D_STORE : pend_v_q ? D_MERGE : D_LONE;
    wdata_o = {dat_i, (dec_o == D_MERGE) ? pend_byte_q : 8'h00};
    be_o    = (dec_o == D_MERGE) ? BE_W : BE_HI;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pend_v_q    <= 1'b0;
      pend_word_q <= '0;
      pend_byte_q <= '0;
    end else if (take_i && dec_o == D_STORE) begin
      pend_v_q    <= 1'b1;
      pend_word_q <= w;
      pend_byte_q <= dat_i;
    end else if (clr_i || (take_i && dec_o == D_MERGE)) begin
      pend_v_q    <= 1'b0;
    end
  assign pend_v_o    = pend_v_q;
  assign pend_word_o = pend_word_q;
  assign pend_byte_o = pend_byte_q;
endmodule

// File: rtl/ldr_sink.sv
// ldr_sink: loader handshake responder packing bytes into 16-bit SDRAM writes.
//   clk_sys, reset              : clock, async active-high reset
//   ldr_adr/wdat/oe/wr, ldr_ack : four-phase byte handshake from the bridge
//   ldr_done                    : sticky, download finished and committed
//   mem_req/addr/wdata/be/ack   : word write port to the SDRAM controller
//   byte_cnt                    : saturating count of accepted bytes
module ldr_sink
  import pc88_ldr_pkg::*;
#(
  parameter int              ADDR_W = 19,
  parameter int              MEM_AW = 24,
  parameter logic [MEM_AW-1:0] BASE = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ldr_adr,
  input  logic [7:0]        ldr_wdat,
  input  logic              ldr_oe,
  input  logic              ldr_wr,
  output logic              ldr_ack,
  output logic              ldr_done,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic [19:0]       byte_cnt
);
  ldr_state_t        state_q, dec_state;
  ldr_dec_t          dec;
  logic [ADDR_W-1:0] adr_q, ev_adr;
  logic [7:0]        dat_q, ev_dat, pend_byte;
  logic [ADDR_W-2:0] pend_word;
  logic [15:0]       pk_wdata;
  logic [1:0]        pk_be;
  logic              oe_q, eof_q, eof_d, pend_v, take, clr;
  logic [MEM_AW-1:0] ev_maddr, pend_maddr;
  // In IDLE the live byte is judged; after a flush the captured one is re-judged.
  always_comb begin
    ev_adr     = (state_q == IDLE) ? ldr_adr : adr_q;
    ev_dat     = (state_q == IDLE) ? ldr_wdat : dat_q;
    take       = (state_q == IDLE && ldr_wr && !ldr_done) ||
                 (state_q == FLUSH && !mem_req && !pend_v);
    clr        = (state_q == FLUSH || state_q == EOF) && mem_req && mem_ack;
    dec_state  = (dec == D_FLUSH) ? FLUSH : (dec == D_STORE) ? ACK : WRITE;
    eof_d      = eof_q | (oe_q & ~ldr_oe);
    ev_maddr   = BASE + MEM_AW'(ev_adr[ADDR_W-1:1]);
    pend_maddr = BASE + MEM_AW'(pend_word);
  end
  ldr_pack #(.ADDR_W(ADDR_W)) u_pack (
    .clk_i(clk_sys), .rst_i(reset), .adr_i(ev_adr), .dat_i(ev_dat),
    .take_i(take), .clr_i(clr), .dec_o(dec), .wdata_o(pk_wdata), .be_o(pk_be),
    .pend_v_o(pend_v), .pend_word_o(pend_word), .pend_byte_o(pend_byte)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      oe_q      <= 1'b0;
      eof_q     <= 1'b0;
      ldr_ack   <= 1'b0;
      ldr_done  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      byte_cnt  <= '0;
    end else begin
      oe_q  <= ldr_oe;
      eof_q <= eof_d;
      case (state_q)
        IDLE:
          if (take) begin
            adr_q    <= ldr_adr;
            dat_q    <= ldr_wdat;
            byte_cnt <= byte_cnt + 20'(byte_cnt != '1);
          end else if (eof_q) begin
            eof_q   <= 1'b0;
            state_q <= EOF;
          end
        // FLUSH and EOF share the pending-byte flush; a request is only raised
        // from an idle port so req never rises and falls in one cycle.
        FLUSH, EOF:
          if (mem_req) begin
            if (mem_ack) mem_req <= 1'b0;
          end else if (pend_v) begin
            mem_req   <= 1'b1;
            mem_addr  <= pend_maddr;
            mem_wdata <= {8'h00, pend_byte};
            mem_be    <= BE_LO;
          end else if (state_q == EOF) begin
            ldr_done <= 1'b1;
            state_q  <= DONE;
          end
        WRITE:
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= ACK;
          end
        ACK:
          if (!ldr_ack) ldr_ack <= 1'b1;
          else if (!ldr_wr) begin
            ldr_ack <= 1'b0;
            state_q <= ldr_done ? DONE : IDLE;
          end
        DONE:
          if (ldr_wr) state_q <= ACK;
        default: state_q <= IDLE;
      endcase
      if (take) begin
        state_q <= dec_state;
        if (dec == D_LONE || dec == D_MERGE) begin
          mem_req   <= 1'b1;
          mem_addr  <= ev_maddr;
          mem_wdata <= pk_wdata;
          mem_be    <= pk_be;
        end
      end
    end
endmodule

// File: tb/tb_ldr_sink.sv
// tb_ldr_sink: directed table-driven bench for ldr_sink.
module tb_ldr_sink;
  logic        clk_sys, reset, ldr_oe, ldr_wr, ldr_ack, ldr_done, mem_req, mem_ack;
  logic [18:0] ldr_adr;
  logic [7:0]  ldr_wdat;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [19:0] byte_cnt;

  typedef struct {
    logic [18:0] adr;
    logic [7:0]  dat;
    int          lat;
    bit          wr;
    logic [23:0] ma;
    logic [15:0] md;
    logic [1:0]  mb;
  } vec_t;
  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } wr_t;

  vec_t tbl[11];
  wr_t  wq[$];
  int   checks = 0, failures = 0, ack_dly = 3, ack_cnt = 0;

  ldr_sink dut (
    .clk_sys(clk_sys), .reset(reset), .ldr_adr(ldr_adr), .ldr_wdat(ldr_wdat),
    .ldr_oe(ldr_oe), .ldr_wr(ldr_wr), .ldr_ack(ldr_ack), .ldr_done(ldr_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .byte_cnt(byte_cnt)
  );

  initial begin
    clk_sys = 0;
    forever #5 clk_sys = ~clk_sys;
  end

  // SDRAM responder: logs each request, acks ack_dly cycles later unless it vanishes.
  initial begin
    mem_ack = 0;
    forever begin
      @(negedge clk_sys);
      if (mem_req) begin
        wq.push_back(wr_t'{mem_addr, mem_wdata, mem_be});
        for (int i = 0; i < ack_dly - 1 && mem_req; i++) @(negedge clk_sys);
        if (mem_req) begin
          mem_ack = 1;
          ack_cnt++;
          @(negedge clk_sys);
          mem_ack = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_wr(input string nm, input logic [23:0] a, input logic [15:0] d, input logic [1:0] b);
    wr_t w;
    if (wq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s no memory write got=none exp=%h/%h/%b", nm, a, d, b);
    end else begin
      w = wq.pop_front();
      chk({nm, "_addr"}, 32'(w.a), 32'(a));
      chk({nm, "_data"}, 32'(w.d), 32'(d));
      chk({nm, "_be"}, 32'(w.b), 32'(b));
    end
  endtask

  task automatic send(input logic [18:0] a, input logic [7:0] d, input int hold, output int lat);
    int bad = 0;
    @(negedge clk_sys);
    ldr_adr = a; ldr_wdat = d; ldr_wr = 1; lat = 0;
    while (!ldr_ack && lat < 100) begin
      @(negedge clk_sys);
      lat++;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_sys);
      if (!ldr_ack) bad++;
    end
    if (hold > 0) chk("hold_ack_high", 32'(bad), 0);
    ldr_wr = 0;
    @(negedge clk_sys);
    chk("ack_fall", 32'(ldr_ack), 0);
  endtask

  task automatic apply(input int k, input int hold);
    int lat;
    send(tbl[k].adr, tbl[k].dat, hold, lat);
    chk($sformatf("lat_row%0d", k), 32'(lat), 32'(tbl[k].lat));
    if (tbl[k].wr) chk_wr($sformatf("wr_row%0d", k), tbl[k].ma, tbl[k].md, tbl[k].mb);
    else chk($sformatf("nowr_row%0d", k), 32'(wq.size()), 0);
  endtask

  task automatic eof_wait(input string nm, input logic [23:0] a, input logic [15:0] d, input logic [1:0] b);
    int a0 = ack_cnt, early = 0, n = 0;
    @(negedge clk_sys);
    ldr_oe = 0;
    while (!ldr_done && n < 100) begin
      @(negedge clk_sys);
      n++;
      if (ldr_done && ack_cnt == a0) early = 1;
    end
    chk({nm, "_done"}, 32'(ldr_done), 1);
    chk({nm, "_done_early"}, 32'(early), 0);
    chk_wr({nm, "_flush"}, a, d, b);
  endtask

  initial begin
    int lat, n;
    tbl[0]  = '{19'h001, 8'hEE, 5, 1, 24'h00, 16'hEE00, 2'b10};
    tbl[1]  = '{19'h000, 8'hAA, 2, 0, 24'h00, 16'h0000, 2'b00};
    tbl[2]  = '{19'h001, 8'hBB, 5, 1, 24'h00, 16'hBBAA, 2'b11};
    tbl[3]  = '{19'h002, 8'hCC, 2, 0, 24'h00, 16'h0000, 2'b00};
    tbl[4]  = '{19'h003, 8'hDD, 5, 1, 24'h01, 16'hDDCC, 2'b11};
    tbl[5]  = '{19'h031, 8'h7E, 5, 1, 24'h18, 16'h7E00, 2'b10};
    tbl[6]  = '{19'h020, 8'h5A, 2, 0, 24'h00, 16'h0000, 2'b00};
    tbl[7]  = '{19'h040, 8'hA5, 7, 1, 24'h10, 16'h005A, 2'b01};
    tbl[8]  = '{19'h010, 8'h11, 2, 0, 24'h00, 16'h0000, 2'b00};
    tbl[9]  = '{19'h011, 8'h22, 5, 1, 24'h08, 16'h2211, 2'b11};
    tbl[10] = '{19'h012, 8'h33, 2, 0, 24'h00, 16'h0000, 2'b00};
    reset = 1; ldr_wr = 0; ldr_oe = 1; ldr_adr = '0; ldr_wdat = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_ack", 32'(ldr_ack), 0);
    chk("rst_done", 32'(ldr_done), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_cnt", 32'(byte_cnt), 0);
    reset = 0;
    // reset while a lone-odd write is outstanding
    ack_dly = 30;
    @(negedge clk_sys);
    ldr_adr = 19'h005; ldr_wdat = 8'h44; ldr_wr = 1; n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("midw_req", 32'(mem_req), 1);
    chk("midw_addr", 32'(mem_addr), 32'h2);
    chk("midw_data", 32'(mem_wdata), 32'h4400);
    @(negedge clk_sys);
    reset = 1;
    #1;
    chk("async_req", 32'(mem_req), 0);
    chk("async_addr", 32'(mem_addr), 0);
    chk("async_data", 32'(mem_wdata), 0);
    chk("async_be", 32'(mem_be), 0);
    chk("async_cnt", 32'(byte_cnt), 0);
    ldr_wr = 0;
    repeat (3) @(negedge clk_sys);
    wq.delete();
    reset = 0; ack_dly = 3;
    for (int k = 0; k <= 7; k++) apply(k, 0);
    chk("cnt_after_p1", 32'(byte_cnt), 8);
    chk("done_p1", 32'(ldr_done), 0);
    eof_wait("eof_a5", 24'h20, 16'h00A5, 2'b01);
    // after done: acked, discarded
    send(19'h050, 8'h99, 0, lat);
    chk("done_lat", 32'(lat), 2);
    chk("done_nowr", 32'(wq.size()), 0);
    chk("done_cnt", 32'(byte_cnt), 8);
    chk("done_sticky", 32'(ldr_done), 1);
    // fresh download: odd length with a held handshake
    @(negedge clk_sys);
    reset = 1; ldr_oe = 1;
    repeat (2) @(negedge clk_sys);
    reset = 0;
    chk("rst2_done", 32'(ldr_done), 0);
    apply(8, 10);
    chk("hold_cnt", 32'(byte_cnt), 1);
    apply(9, 0);
    apply(10, 0);
    eof_wait("eof_33", 24'h09, 16'h0033, 2'b01);
    chk("cnt_p2", 32'(byte_cnt), 3);
    chk("no_extra_wr", 32'(wq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ldr_sink.md
Name: ldr_sink

Overview:
- Responder end of the loader handshake (LOADER_ADR/WDAT/WR/ACK/DONE) between the HPS ioctl bridge and the PC88 core.
- Accepts one byte per four-phase handshake and packs even/odd byte pairs into 16-bit little-endian words.
- Issues word writes with byte enables to the SDRAM controller's loader write port.
- Flushes any half-filled word at end of download, then raises a sticky done flag.

Parameters:
- ADDR_W, 19, loader byte-address width.
- MEM_AW, 24, SDRAM word-address width.
- BASE, 0, word offset added to every memory address (MEM_AW bits).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ldr_adr  in  ADDR_W  byte address; valid while ldr_wr is high.
- ldr_wdat  in  8  byte data; valid while ldr_wr is high.
- ldr_oe  in  1  download window; high while a ROM download is active.
- ldr_wr  in  1  write request level; held high until ldr_ack rises.
- ldr_ack  out  1  acknowledge level.
- ldr_done  out  1  sticky: download finished and all data committed to memory.
- mem_req  out  1  write request to the SDRAM controller; held until mem_ack.
- mem_addr  out  MEM_AW  word address = BASE + ldr_adr[ADDR_W-1:1].
- mem_wdata  out  16  write data: [7:0] even byte, [15:8] odd byte.
- mem_be  out  2  byte enables: [0] even byte, [1] odd byte.
- mem_ack  in  1  one-cycle pulse; write accepted.
- byte_cnt  out  20  number of bytes accepted since reset.

Behaviour:
- Reset values: ldr_ack=0, ldr_done=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, byte_cnt=0; pending buffer invalid; state IDLE.
- Reset asserted mid-operation drops mem_req immediately (asynchronous). The SDRAM controller must abandon the request.
- Pending buffer: pend_v, pend_word[ADDR_W-2:0], pend_byte[7:0]. It only ever holds an even byte.
- States: IDLE, FLUSH, WRITE, ACK, EOF, DONE.
- IDLE, with ldr_wr=1 and ldr_done=0:
  - Capture adr/wdat and increment byte_cnt. Let w = adr[ADDR_W-1:1] and odd = adr[0].
  - If pend_v=1 and (w != pend_word or odd=0): go to FLUSH. The new byte stays captured and is processed again after the flush.
  - Else if odd=0: pend_byte <= data, pend_word <= w, pend_v <= 1; go to ACK. No memory write.
  - Else if odd=1 and pend_v=1 and w == pend_word: write word {data, pend_byte} with be=11; clear pend_v; go to WRITE.
  - Else (odd=1, no pending): write {data, 8'h00} with be=10; go to WRITE.
- FLUSH:
  - mem_req=1 with be=01 and data {8'h00, pend_byte}; clear pend_v on mem_ack.
  - Then re-evaluate the captured byte using the IDLE rules, without incrementing byte_cnt again.
- WRITE: mem_req=1 with address, data and be stable until mem_ack; go to ACK on mem_ack.
- ACK:
  - ldr_ack=1, one cycle after entry at the earliest.
  - Hold until ldr_wr=0, then ldr_ack=0 and go to IDLE.
  - ldr_wr is never sampled as a new request while ldr_ack=1.
- Latency from ldr_wr rise to ldr_ack rise:
  - Even byte, no flush: 2 cycles.
  - Word write: 2 cycles + mem_ack wait.
  - Flush adds one more memory transaction.
- End of download: a falling edge of ldr_oe (registered compare) sets an eof flag.
- eof is acted on only in IDLE with ldr_wr=0. The in-flight byte always completes first.
- EOF state: if pend_v=1, flush as in FLUSH. Then go to DONE.
- DONE: ldr_done=1 (sticky until reset). Any further ldr_wr is acked via ACK but discarded: no byte_cnt increment, no memory write. This prevents the bridge from deadlocking.
- Simultaneous ldr_oe fall and ldr_wr rise in IDLE: the byte is accepted first, then EOF.
- ldr_adr wrap: addresses are used modulo 2^ADDR_W. mem_addr addition wraps modulo 2^MEM_AW.
- byte_cnt saturates at 20'hFFFFF.
- mem_req never rises and falls in the same cycle. There is at most one outstanding memory request.

Decomposition:
- Shared package pc88_ldr_pkg holds:
  - the state enum ldr_state_t;
  - byte-enable constants BE_LO=2'b01, BE_HI=2'b10, BE_W=2'b11.
- One natural sub-module: ldr_pack, the pending-byte buffer plus the merge/flush decision logic (combinational decision, registered buffer).
- The FSM and handshake stay in ldr_sink.

Test Plan:
- Sequential bytes 0x00..0x03 = AA,BB,CC,DD, mem_ack 3 cycles after req:
  - writes (BASE+0, BBAA, be 11) and (BASE+1, DDCC, be 11);
  - 4 acks; byte_cnt=4; ldr_done=0.
- Odd-length download 0x10..0x12 = 11,22,33, then ldr_oe falls:
  - writes (8, 2211, be 11), then flush (9, 0033, be 01);
  - ldr_done=1 only after the second mem_ack.
- Non-consecutive even bytes 0x20=5A then 0x40=A5:
  - flush (0x10, 005A, be 01) before the second ack;
  - A5 remains pending until EOF, then (0x20, 00A5, be 01).
- Lone odd byte 0x31=7E: write (0x18, 7E00, be 10), no pending left.
- Handshake hold: keep ldr_wr high 10 cycles after ldr_ack rises:
  - ldr_ack stays high, no second capture, byte_cnt increments once;
  - ldr_ack falls the cycle after ldr_wr falls.
- Reset mid-WRITE (mem_req=1):
  - all outputs zero asynchronously;
  - after release, byte 0x01=EE gives write (0, EE00, be 10), byte_cnt=1.
- After ldr_done, ldr_wr pulse: acked, no mem_req, byte_cnt unchanged.
